soc_oci_dct_trace_arbiter: RTL and testbench

//  Shares one debug-control-trace (DCT) capture buffer between the NUM_CPUS Nios II OCI blocks of the MPSoC.

---
 rtl/soc_oci_dct_trace_arbiter.sv | 154 +++++++++++++++
 tb/tb_soc_oci_dct_trace_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_oci_dct_trace_arbiter.sv
// soc_oci_dct_trace_arbiter
//   Shares one debug-control-trace (DCT) capture FIFO between NUM_CPUS OCI blocks.
//   A round-robin arbiter accepts at most one record per cycle and stores it,
//   tagged with the CPU id, in a show-ahead FIFO that a host/JTAG side drains.
//   test_ending_i freezes capture; once the FIFO has drained test_has_ended_o rises.
// Ports
//   clk_i, reset_i         clock, synchronous active-high reset
//   req_valid_i/_ready_o   per-CPU offer / one-hot accept
//   req_buffer_i           CPU i record at [i*DATA_W +: DATA_W]
//   req_count_i            CPU i count  at [i*CNT_W +: CNT_W]
//   rd_valid_o/_ready_i    FIFO head handshake, rd_data_o = {cpu_id, count, buffer}
//   fill_level_o           FIFO occupancy
//   clamp_err_o            sticky: a record arrived with count > 3
//   test_ending_i          freeze-and-drain request
//   test_has_ended_o       sticky: frozen and FIFO empty
module soc_oci_dct_trace_arbiter #(
   parameter int unsigned NUM_CPUS = 4,
   parameter int unsigned DATA_W   = 30,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AW       = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_CPUS-1:0]           req_valid_i,
   input  logic [NUM_CPUS*DATA_W-1:0]    req_buffer_i,
   input  logic [NUM_CPUS*CNT_W-1:0]     req_count_i,
   output logic [NUM_CPUS-1:0]           req_ready_o,
   output logic                          rd_valid_o,
   input  logic                          rd_ready_i,
   output logic [ID_W+CNT_W+DATA_W-1:0]  rd_data_o,
   output logic [AW:0]                   fill_level_o,
   output logic                          clamp_err_o,
   input  logic                          test_ending_i,
   output logic                          test_has_ended_o
);

   localparam int unsigned       RecW      = ID_W + CNT_W + DATA_W;
   localparam logic [AW:0]       FullLevel = (AW+1)'(DEPTH);
   localparam logic [CNT_W-1:0]  MaxCnt    = CNT_W'(3);

   typedef enum logic [1:0] {StRun, StDrain, StEnded} state_e;

   state_e            state_q;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]       fill_q, fill_d;
   logic              clamp_err_q;
   logic              ended_q;
   logic [RecW-1:0]   mem_q [DEPTH];

   logic              full, empty;
   logic              grant_found;
   logic [ID_W-1:0]   grant_idx;
   logic [DATA_W-1:0] sel_buf;
   logic [CNT_W-1:0]  sel_cnt;
   logic [CNT_W-1:0]  store_cnt;
   logic              push, pop, clamp;
   logic [RecW-1:0]   wr_data;

   // (base + off) mod NUM_CPUS without a divider; off is always < NUM_CPUS.
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                input int unsigned   off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_CPUS) s = s - NUM_CPUS;
      return ID_W'(s);
   endfunction

   // Full is the registered occupancy only, so a same-cycle pop never frees a slot.
   assign full  = (fill_q == FullLevel);
   assign empty = (fill_q == '0);

   // Round-robin scan starting at rr_ptr_q.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      if (state_q == StRun && !full && !reset_i) begin
         for (int unsigned i = 0; i < NUM_CPUS; i++) begin
            if (!grant_found && req_valid_i[wrap_idx(rr_ptr_q, i)]) begin
               grant_found = 1'b1;
               grant_idx   = wrap_idx(rr_ptr_q, i);
            end
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (grant_found) req_ready_o[grant_idx] = 1'b1;
   end

   assign sel_buf   = req_buffer_i[grant_idx*DATA_W +: DATA_W];
   assign sel_cnt   = req_count_i[grant_idx*CNT_W +: CNT_W];
   assign clamp     = grant_found && (sel_cnt > MaxCnt);
   assign store_cnt = clamp ? MaxCnt : sel_cnt;
   // A zero-count record completes its handshake but is dropped.
   assign push      = grant_found && (sel_cnt != '0);
   assign pop       = rd_valid_o && rd_ready_i;
   assign wr_data   = {grant_idx, store_cnt, sel_buf};
   assign rr_ptr_d  = grant_found ? wrap_idx(grant_idx, 1) : rr_ptr_q;

   always_comb begin
      fill_d = fill_q;
      if (push && !pop)      fill_d = fill_q + 1'b1;
      else if (!push && pop) fill_d = fill_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StRun;
         rr_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         clamp_err_q <= 1'b0;
         ended_q     <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         fill_q   <= fill_d;
         if (push)  wr_ptr_q    <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q    <= rd_ptr_q + 1'b1;
         if (clamp) clamp_err_q <= 1'b1;
         case (state_q)
            StRun: begin
               if (test_ending_i) state_q <= StDrain;
            end
            StDrain: begin
               if (empty) begin
                  state_q <= StEnded;
                  ended_q <= 1'b1;
               end
            end
            StEnded: begin
               ended_q <= 1'b1;
            end
            default: state_q <= StRun;
         endcase
      end
   end

   // Storage has no reset; rd_data_o is masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   assign rd_valid_o       = !empty;
   assign rd_data_o        = rd_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   assign fill_level_o     = fill_q;
   assign clamp_err_o      = clamp_err_q;
   assign test_has_ended_o = ended_q;

endmodule

// File: tb/tb_soc_oci_dct_trace_arbiter.sv
// Testbench for soc_oci_dct_trace_arbiter: directed scenarios with hand-computed
// grants; accepted records go to a scoreboard queue that a negedge monitor
// compares against rd_data_o on every pop.
module tb_soc_oci_dct_trace_arbiter;

   localparam int unsigned NUM_CPUS = 4;
   localparam int unsigned DATA_W   = 30;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned ID_W     = 2;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned AW       = 4;
   localparam int unsigned RecW     = ID_W + CNT_W + DATA_W;

   logic                       clk;
   logic                       reset;
   logic [NUM_CPUS-1:0]        valid;
   logic [NUM_CPUS*DATA_W-1:0] bufs;
   logic [NUM_CPUS*CNT_W-1:0]  cnts;
   logic [NUM_CPUS-1:0]        req_ready;
   logic                       rd_valid;
   logic                       rd_ready;
   logic [RecW-1:0]            rd_data;
   logic [AW:0]                fill;
   logic                       clamp_err;
   logic                       test_ending;
   logic                       ended;

   logic [RecW-1:0] sb[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   int              grants[NUM_CPUS];

   soc_oci_dct_trace_arbiter #(
      .NUM_CPUS(NUM_CPUS), .DATA_W(DATA_W), .CNT_W(CNT_W),
      .ID_W(ID_W), .DEPTH(DEPTH), .AW(AW)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .req_valid_i      (valid),
      .req_buffer_i     (bufs),
      .req_count_i      (cnts),
      .req_ready_o      (req_ready),
      .rd_valid_o       (rd_valid),
      .rd_ready_i       (rd_ready),
      .rd_data_o        (rd_data),
      .fill_level_o     (fill),
      .clamp_err_o      (clamp_err),
      .test_ending_i    (test_ending),
      .test_has_ended_o (ended)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1 with inputs set; checks the grant, records the
   // expected FIFO entry, returns at the next posedge+1.
   task automatic step(input logic [NUM_CPUS-1:0] exp_ready, input string name);
      logic [CNT_W-1:0] c;
      #2;
      check({name, " ready"}, 64'(req_ready), 64'(exp_ready));
      for (int i = 0; i < NUM_CPUS; i++) if (req_ready[i]) grants[i]++;
      for (int i = 0; i < NUM_CPUS; i++) begin
         if (exp_ready[i]) begin
            c = cnts[i*CNT_W +: CNT_W];
            if (c != '0)
               sb.push_back({ID_W'(i), (c > 4'd3) ? 4'd3 : c, bufs[i*DATA_W +: DATA_W]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      valid       = '0;
      rd_ready    = 1'b0;
      test_ending = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Scoreboard monitor: compare the head on every pop.
   always @(negedge clk) begin
      if (!reset && rd_valid && rd_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_data unexpected: got %0h, expected no record", rd_data);
         end else begin
            check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
         end
      end
   end

   initial begin
      reset       = 1'b1;
      valid       = '1;
      bufs        = '0;
      cnts        = '0;
      rd_ready    = 1'b0;
      test_ending = 1'b0;
      foreach (grants[i]) grants[i] = 0;
      @(posedge clk);
      #3;
      check("reset req_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      valid = '0;
      check("reset rd_valid", 64'(rd_valid), 64'(0));
      check("reset rd_data", 64'(rd_data), 64'(0));
      check("reset fill", 64'(fill), 64'(0));
      check("reset clamp_err", 64'(clamp_err), 64'(0));
      check("reset ended", 64'(ended), 64'(0));

      // 1: single record, one-cycle latency.
      valid = 4'b0001;
      bufs[0 +: DATA_W] = 30'h3ABCDEF0;
      cnts[0 +: CNT_W]  = 4'd3;
      step(4'b0001, "t1 accept");
      valid = '0;
      check("t1 rd_valid", 64'(rd_valid), 64'(1));
      check("t1 rd_data", 64'(rd_data), 64'({2'd0, 4'd3, 30'h3ABCDEF0}));
      check("t1 fill", 64'(fill), 64'(1));
      rd_ready = 1'b1;
      step(4'b0000, "t1 drain");
      check("t1 fill drained", 64'(fill), 64'(0));

      // 2: all valid; rr_ptr is 1 after test 1, so grants go 1,2,3,0,...
      foreach (grants[i]) grants[i] = 0;
      valid = 4'b1111;
      cnts  = {4'd1, 4'd3, 4'd2, 4'd1};
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < NUM_CPUS; i++) bufs[i*DATA_W +: DATA_W] = 30'(j*16 + i);
         step(4'(1 << ((j + 1) % 4)), "t2 rr");
      end
      valid = '0;
      step(4'b0000, "t2 drain");
      check("t2 fill", 64'(fill), 64'(0));
      for (int i = 0; i < NUM_CPUS; i++) check("t2 grant share", 64'(grants[i]), 64'(4));
      check("t2 clamp_err", 64'(clamp_err), 64'(0));

      // 3: fill to full from CPU2 (rr_ptr=1 -> CPU2 first).
      rd_ready = 1'b0;
      valid    = 4'b0100;
      cnts     = {4'd0, 4'd1, 4'd0, 4'd0};
      for (int j = 0; j < 20; j++) begin
         bufs[2*DATA_W +: DATA_W] = 30'(32'h2000 + j);
         step((j < 16) ? 4'b0100 : 4'b0000, "t3 fill");
      end
      check("t3 fill full", 64'(fill), 64'(16));
      check("t3 rd_valid", 64'(rd_valid), 64'(1));
      rd_ready = 1'b1;
      step(4'b0000, "t3 pop cycle no push");
      check("t3 fill after pop", 64'(fill), 64'(15));
      rd_ready = 1'b0;
      step(4'b0100, "t3 refill");
      check("t3 fill refilled", 64'(fill), 64'(16));
      step(4'b0000, "t3 full again");
      valid    = '0;
      rd_ready = 1'b1;
      repeat (16) step(4'b0000, "t3 drain");
      check("t3 fill drained", 64'(fill), 64'(0));
      check("t3 rd_valid drained", 64'(rd_valid), 64'(0));

      // 4: rr_ptr=3. CPU1 cnt=0 dropped, rr_ptr->2; then CPU2 wins over CPU1.
      rd_ready = 1'b0;
      valid    = 4'b0010;
      cnts     = '0;
      bufs[1*DATA_W +: DATA_W] = 30'h1111111;
      step(4'b0010, "t4 cnt0");
      check("t4 cnt0 not stored", 64'(fill), 64'(0));
      valid = 4'b0110;
      cnts[1*CNT_W +: CNT_W]   = 4'd9;
      cnts[2*CNT_W +: CNT_W]   = 4'd2;
      bufs[2*DATA_W +: DATA_W] = 30'h2222222;
      step(4'b0100, "t4 rr advanced");
      check("t4 clamp before", 64'(clamp_err), 64'(0));
      valid = 4'b0010;
      step(4'b0010, "t4 clamp");
      check("t4 clamp_err", 64'(clamp_err), 64'(1));
      check("t4 fill", 64'(fill), 64'(2));
      valid    = '0;
      rd_ready = 1'b1;
      repeat (2) step(4'b0000, "t4 drain");
      check("t4 clamp sticky", 64'(clamp_err), 64'(1));

      // 5: 8 queued, test_ending with CPU3 push, then drain to ENDED.
      rd_ready = 1'b0;
      valid    = 4'b0001;
      cnts     = {4'd1, 4'd0, 4'd0, 4'd2};
      bufs[0 +: DATA_W]        = 30'h0AAAAAA;
      bufs[3*DATA_W +: DATA_W] = 30'h3333333;
      repeat (8) step(4'b0001, "t5 fill");
      check("t5 fill 8", 64'(fill), 64'(8));
      valid       = 4'b1000;
      test_ending = 1'b1;
      step(4'b1000, "t5 push with test_ending");
      test_ending = 1'b0;
      step(4'b0000, "t5 drain gate");
      check("t5 fill 9", 64'(fill), 64'(9));
      rd_ready = 1'b1;
      repeat (9) step(4'b0000, "t5 drain");
      check("t5 fill empty", 64'(fill), 64'(0));
      step(4'b0000, "t5 to ended");
      check("t5 ended", 64'(ended), 64'(1));
      test_ending = 1'b1;
      valid       = 4'b1111;
      cnts        = {4'd1, 4'd1, 4'd1, 4'd1};
      repeat (3) step(4'b0000, "t5 ended frozen");
      check("t5 ended sticky", 64'(ended), 64'(1));
      check("t5 fill frozen", 64'(fill), 64'(0));

      // 6: half full in DRAIN, then reset.
      do_reset();
      check("t6 clamp cleared", 64'(clamp_err), 64'(0));
      valid = 4'b0010;
      cnts[1*CNT_W +: CNT_W]   = 4'd3;
      bufs[1*DATA_W +: DATA_W] = 30'h1234567;
      repeat (8) step(4'b0010, "t6 fill");
      valid       = '0;
      test_ending = 1'b1;
      step(4'b0000, "t6 test_ending");
      test_ending = 1'b0;
      valid       = 4'b0010;
      step(4'b0000, "t6 drain gate");
      check("t6 fill 8", 64'(fill), 64'(8));
      check("t6 not ended", 64'(ended), 64'(0));
      do_reset();
      check("t6 fill", 64'(fill), 64'(0));
      check("t6 rd_valid", 64'(rd_valid), 64'(0));
      check("t6 rd_data", 64'(rd_data), 64'(0));
      check("t6 ended", 64'(ended), 64'(0));
      valid = 4'b1111;
      cnts  = {4'd1, 4'd1, 4'd1, 4'd1};
      step(4'b0001, "t6 run rr0");
      step(4'b0010, "t6 run rr1");
      valid    = '0;
      rd_ready = 1'b1;
      repeat (2) step(4'b0000, "t6 drain");
      check("t6 fill drained", 64'(fill), 64'(0));

      check("scoreboard empty", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
